// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the baud
// divider helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // System clocks per bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input that idles high.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset; both flops reset to 1
//   async_i in  asynchronous input
//   sync_o  out input synchronised to clk
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Samples each bit at mid-bit, presents good bytes with a
// one-cycle strobe and an unread flag, and flags framing errors and overruns.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx           in   asynchronous serial line, idle high
//   rx_ack       in   consumer has taken rx_data; clears rx_ready
//   rx_data      out  last good byte, LSB first on the line
//   rx_valid     out  1-cycle pulse when rx_data updates
//   rx_ready     out  unread byte present
//   rx_frame_err out  1-cycle pulse when the stop bit is sampled low
//   rx_overrun   out  1-cycle pulse when a good byte lands on an unread one
//   rx_busy      out  high whenever the FSM is outside IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  // Divider must fit the counter and leave room for a non-zero half bit.
  if (BAUD_DIV > 65535 || BAUD_DIV < 4) begin : g_bad_baud_div
    $error("uart_rx: BAUD_DIV out of range 4..65535");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx),
    .sync_o (rx_s)
  );

  rx_state_e            state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ready_q,  ready_d;
  logic                 ferr_q,   ferr_d;
  logic                 ovr_q,    ovr_d;
  logic                 busy_q,   busy_d;

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    // A new byte below overrides this clear: the fresh byte is unread.
    ready_d   = rx_ack ? 1'b0 : ready_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = ready_q;
            ready_d = 1'b1;
          end else begin
            state_d = ST_BREAK;
            ferr_d  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line recovers so a stuck-low line yields one error.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_ready     = ready_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers on one clock (100 MHz/115200, 10 MHz/115200,
// 10 MHz/9600), each with its own line, checked against a frame-level model.
module tb_uart_rx;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a    [NI];
  logic       ack_a   [NI];
  logic [7:0] data_a  [NI];
  logic       valid_a [NI];
  logic       ready_a [NI];
  logic       ferr_a  [NI];
  logic       ovr_a   [NI];
  logic       busy_a  [NI];

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLK_FREQ(100_000_000), .BAUD_RATE(115200)) u_def (
    .clk(clk), .rst_n(rst_n), .rx(rx_a[0]), .rx_ack(ack_a[0]),
    .rx_data(data_a[0]), .rx_valid(valid_a[0]), .rx_ready(ready_a[0]),
    .rx_frame_err(ferr_a[0]), .rx_overrun(ovr_a[0]), .rx_busy(busy_a[0]));

  uart_rx #(.CLK_FREQ(10_000_000), .BAUD_RATE(115200)) u_fast (
    .clk(clk), .rst_n(rst_n), .rx(rx_a[1]), .rx_ack(ack_a[1]),
    .rx_data(data_a[1]), .rx_valid(valid_a[1]), .rx_ready(ready_a[1]),
    .rx_frame_err(ferr_a[1]), .rx_overrun(ovr_a[1]), .rx_busy(busy_a[1]));

  uart_rx #(.CLK_FREQ(10_000_000), .BAUD_RATE(9600)) u_slow (
    .clk(clk), .rst_n(rst_n), .rx(rx_a[2]), .rx_ack(ack_a[2]),
    .rx_data(data_a[2]), .rx_valid(valid_a[2]), .rx_ready(ready_a[2]),
    .rx_frame_err(ferr_a[2]), .rx_overrun(ovr_a[2]), .rx_busy(busy_a[2]));

  // ---------------- observed events ----------------
  typedef struct {
    int          inst;
    bit          ferr;
    int unsigned cyc;
    logic [7:0]  data;
    logic        ovr;
  } ev_t;

  ev_t evq[$];
  ev_t gotv[$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (valid_a[i] === 1'b1) evq.push_back('{i, 1'b0, cyc, data_a[i], ovr_a[i]});
      if (ferr_a[i] === 1'b1)  evq.push_back('{i, 1'b1, cyc, 8'h00, 1'b0});
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  data;
    logic        ovr;
    int unsigned e0;
  } exp_t;

  exp_t       expq[$];
  bit         mready [NI];
  logic [7:0] mlast  [NI];

  function automatic int unsigned div_of(input int i);
    case (i)
      0:       return 100_000_000 / 115200;
      1:       return 10_000_000 / 115200;
      default: return 10_000_000 / 9600;
    endcase
  endfunction

  // Cycle at which rx_valid should be seen for a frame whose start is first
  // sampled at edge e0: sync (2) + IDLE decision (1) + half bit + 9 bits.
  function automatic int unsigned exp_cyc(input int unsigned e0, input int i);
    return e0 + 3 + div_of(i) / 2 + 9 * div_of(i);
  endfunction

  function automatic bit lat_ok(input int unsigned got, input int unsigned e0, input int i);
    int d;
    d = int'(got) - int'(exp_cyc(e0, i));
    return (d >= -1) && (d <= 1);
  endfunction

  function automatic void model_good(input int i, input logic [7:0] b, input int unsigned e0);
    expq.push_back('{b, logic'(mready[i]), e0});
    mready[i] = 1'b1;
    mlast[i]  = b;
  endfunction

  function automatic void model_ack(input int i);
    mready[i] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      mready[i] = 1'b0;
      mlast[i]  = 8'h00;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int unsigned n);
    if (n == 0) return;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; e0 is the first edge that samples the start bit.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop,
                            output int unsigned e0);
    int unsigned bd;
    bd = div_of(i);
    rx_a[i] = 1'b0;
    e0 = cyc + 1;
    idle(bd);
    for (int k = 0; k < 8; k++) begin
      rx_a[i] = b[k];
      idle(bd);
    end
    rx_a[i] = stop;
    idle(bd);
  endtask

  task automatic split_events(input int i, output int nf);
    gotv.delete();
    nf = 0;
    foreach (evq[k]) begin
      if (evq[k].inst == i) begin
        if (evq[k].ferr) nf++;
        else gotv.push_back(evq[k]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if ({data_a[i], valid_a[i], ready_a[i], ferr_a[i], ovr_a[i], busy_a[i]} !== 13'h0) begin
        n_err++;
        $display("FAIL reset inst%0d: outputs=%h want 0", i,
                 {data_a[i], valid_a[i], ready_a[i], ferr_a[i], ovr_a[i], busy_a[i]});
      end
    end
  endtask

  task automatic test_single(input int i, input logic [7:0] b);
    int unsigned e0;
    int nf;
    evq.delete();
    expq.delete();
    send_frame(i, b, 1'b1, e0);
    model_good(i, b, e0);
    idle(4);
    split_events(i, nf);
    n_vec++;
    if (gotv.size() != 1) begin
      n_err++;
      $display("FAIL single inst%0d count: got %0d want 1", i, gotv.size());
    end else begin
      n_vec++;
      if (gotv[0].data !== expq[0].data || gotv[0].ovr !== expq[0].ovr) begin
        n_err++;
        $display("FAIL single inst%0d byte: got %h/%b want %h/%b", i,
                 gotv[0].data, gotv[0].ovr, expq[0].data, expq[0].ovr);
      end
      n_vec++;
      if (!lat_ok(gotv[0].cyc, e0, i)) begin
        n_err++;
        $display("FAIL single inst%0d latency: got cyc %0d want %0d+-1", i,
                 gotv[0].cyc, exp_cyc(e0, i));
      end
    end
    n_vec++;
    if (nf != 0) begin
      n_err++;
      $display("FAIL single inst%0d frame_err: got %0d pulses want 0", i, nf);
    end
    n_vec++;
    if (ready_a[i] !== mready[i] || data_a[i] !== mlast[i]) begin
      n_err++;
      $display("FAIL single inst%0d ready/data: got %b/%h want %b/%h", i,
               ready_a[i], data_a[i], mready[i], mlast[i]);
    end
    ack_a[i] = 1'b1;
    idle(1);
    ack_a[i] = 1'b0;
    model_ack(i);
    idle(1);
    n_vec++;
    if (ready_a[i] !== mready[i]) begin
      n_err++;
      $display("FAIL single inst%0d ack: got ready %b want %b", i, ready_a[i], mready[i]);
    end
  endtask

  task automatic test_glitch();
    int unsigned e0;
    int unsigned fall;
    evq.delete();
    rx_a[0] = 1'b0;
    e0 = cyc + 1;
    idle(200);
    rx_a[0] = 1'b1;
    n_vec++;
    if (busy_a[0] !== 1'b1) begin
      n_err++;
      $display("FAIL glitch busy: got %b want 1 during glitch", busy_a[0]);
    end
    fall = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (busy_a[0] === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (fall == 0 || int'(fall) - int'(e0 + 434 + 3) < -1 || int'(fall) - int'(e0 + 434 + 3) > 1) begin
      n_err++;
      $display("FAIL glitch busy_fall: got cyc %0d want %0d+-1", fall, e0 + 434 + 3);
    end
    idle(100);
    n_vec++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL glitch pulses: got %0d events want 0", evq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int unsigned e0;
    int nf;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    evq.delete();
    expq.delete();
    // Consumer acks continuously, so no overrun is expected.
    ack_a[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_ack(1);
      send_frame(1, bytes[k], 1'b1, e0);
      model_good(1, bytes[k], e0);
    end
    idle(4);
    ack_a[1] = 1'b0;
    model_ack(1);
    idle(1);
    split_events(1, nf);
    n_vec++;
    if (gotv.size() != expq.size()) begin
      n_err++;
      $display("FAIL b2b count: got %0d want %0d", gotv.size(), expq.size());
    end
    for (int k = 0; k < gotv.size() && k < expq.size(); k++) begin
      n_vec++;
      if (gotv[k].data !== expq[k].data || gotv[k].ovr !== expq[k].ovr ||
          !lat_ok(gotv[k].cyc, expq[k].e0, 1)) begin
        n_err++;
        $display("FAIL b2b byte%0d: got %h/%b@%0d want %h/%b@%0d", k, gotv[k].data,
                 gotv[k].ovr, gotv[k].cyc, expq[k].data, expq[k].ovr, exp_cyc(expq[k].e0, 1));
      end
    end
    n_vec++;
    if (nf != 0 || ready_a[1] !== mready[1]) begin
      n_err++;
      $display("FAIL b2b errs/ready: got ferr %0d ready %b want 0/%b", nf, ready_a[1], mready[1]);
    end
  endtask

  task automatic test_frame_err();
    int unsigned e0;
    int nf;
    evq.delete();
    send_frame(1, 8'h3C, 1'b0, e0);
    idle(3 * div_of(1));
    n_vec++;
    if (busy_a[1] !== 1'b1) begin
      n_err++;
      $display("FAIL ferr busy_low: got %b want 1", busy_a[1]);
    end
    rx_a[1] = 1'b1;
    idle(6);
    n_vec++;
    if (busy_a[1] !== 1'b0) begin
      n_err++;
      $display("FAIL ferr busy_release: got %b want 0", busy_a[1]);
    end
    split_events(1, nf);
    n_vec++;
    if (nf != 1 || gotv.size() != 0) begin
      n_err++;
      $display("FAIL ferr pulses: got ferr %0d valid %0d want 1/0", nf, gotv.size());
    end
    n_vec++;
    if (data_a[1] !== mlast[1] || ready_a[1] !== mready[1]) begin
      n_err++;
      $display("FAIL ferr data: got %h/%b want %h/%b", data_a[1], ready_a[1], mlast[1], mready[1]);
    end
  endtask

  task automatic test_overrun();
    int unsigned e0a, e0b, e0c, lat, lat_nom, set;
    int nf;
    logic r_mid;
    evq.delete();
    expq.delete();
    ack_a[1] = 1'b1;
    idle(1);
    ack_a[1] = 1'b0;
    model_ack(1);
    send_frame(1, 8'h11, 1'b1, e0a);
    model_good(1, 8'h11, e0a);
    send_frame(1, 8'h22, 1'b1, e0b);
    model_good(1, 8'h22, e0b);
    split_events(1, nf);
    n_vec++;
    if (gotv.size() != 2) begin
      n_err++;
      $display("FAIL ovr count: got %0d want 2", gotv.size());
    end
    for (int k = 0; k < gotv.size() && k < 2; k++) begin
      n_vec++;
      if (gotv[k].data !== expq[k].data || gotv[k].ovr !== expq[k].ovr) begin
        n_err++;
        $display("FAIL ovr byte%0d: got %h/%b want %h/%b", k, gotv[k].data, gotv[k].ovr,
                 expq[k].data, expq[k].ovr);
      end
    end
    // Align the ack with the edge that sets rx_ready for the third byte.
    lat_nom = exp_cyc(0, 1);
    lat = (gotv.size() == 2 && lat_ok(gotv[1].cyc, e0b, 1)) ? gotv[1].cyc - e0b : lat_nom;
    evq.delete();
    expq.delete();
    e0c = cyc + 1;
    set = e0c + lat;
    r_mid = 1'bx;
    fork
      send_frame(1, 8'h33, 1'b1, e0c);
      begin
        repeat (set - 2 - cyc) @(posedge clk);
        #1;
        ack_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_mid = ready_a[1];
        @(posedge clk);
        #1;
        ack_a[1] = 1'b0;
      end
    join
    model_ack(1);
    n_vec++;
    if (r_mid !== mready[1]) begin
      n_err++;
      $display("FAIL ovr ack_clear: got ready %b want %b", r_mid, mready[1]);
    end
    model_good(1, 8'h33, e0c);
    idle(4);
    split_events(1, nf);
    n_vec++;
    if (gotv.size() != 1 || gotv[0].data !== expq[0].data || gotv[0].ovr !== expq[0].ovr) begin
      n_err++;
      $display("FAIL ovr third: got %0d events first %h/%b want 1 event %h/%b", gotv.size(),
               gotv.size() > 0 ? gotv[0].data : 8'hxx, gotv.size() > 0 ? gotv[0].ovr : 1'bx,
               expq[0].data, expq[0].ovr);
    end
    n_vec++;
    if (ready_a[1] !== mready[1]) begin
      n_err++;
      $display("FAIL ovr set_wins: got ready %b want %b", ready_a[1], mready[1]);
    end
  endtask

  task automatic test_random();
    int unsigned e0, gap;
    int nf;
    logic [7:0] b;
    evq.delete();
    expq.delete();
    for (int n = 0; n < 6; n++) begin
      gap = $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1) begin
        ack_a[1] = 1'b1;
        idle(1);
        ack_a[1] = 1'b0;
        model_ack(1);
        if (gap > 0) gap = gap - 1;
      end
      idle(gap);
      b = 8'($urandom);
      send_frame(1, b, 1'b1, e0);
      model_good(1, b, e0);
    end
    idle(4);
    split_events(1, nf);
    n_vec++;
    if (gotv.size() != expq.size() || nf != 0) begin
      n_err++;
      $display("FAIL random count: got %0d valid %0d ferr want %0d/0", gotv.size(), nf, expq.size());
    end
    for (int k = 0; k < gotv.size() && k < expq.size(); k++) begin
      n_vec++;
      if (gotv[k].data !== expq[k].data || gotv[k].ovr !== expq[k].ovr ||
          !lat_ok(gotv[k].cyc, expq[k].e0, 1)) begin
        n_err++;
        $display("FAIL random byte%0d: got %h/%b@%0d want %h/%b@%0d", k, gotv[k].data,
                 gotv[k].ovr, gotv[k].cyc, expq[k].data, expq[k].ovr, exp_cyc(expq[k].e0, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned bd, e0;
    int nf;
    logic [7:0] b;
    bd = div_of(1);
    b  = 8'h81;
    rx_a[1] = 1'b0;
    idle(bd);
    for (int k = 0; k < 4; k++) begin
      rx_a[1] = b[k];
      idle(bd);
    end
    rx_a[1] = b[4];
    idle(bd / 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    n_vec++;
    if ({data_a[1], valid_a[1], ready_a[1], ferr_a[1], ovr_a[1], busy_a[1]} !==
        {mlast[1], 1'b0, mready[1], 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid outputs: got %h want 0",
               {data_a[1], valid_a[1], ready_a[1], ferr_a[1], ovr_a[1], busy_a[1]});
    end
    evq.delete();
    rx_a[1] = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(12 * bd);
    n_vec++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid pulses: got %0d events want 0", evq.size());
    end
    expq.delete();
    send_frame(1, b, 1'b1, e0);
    model_good(1, b, e0);
    idle(4);
    split_events(1, nf);
    n_vec++;
    if (gotv.size() != 1 || nf != 0 || gotv[0].data !== expq[0].data ||
        gotv[0].ovr !== expq[0].ovr || !lat_ok(gotv[0].cyc, e0, 1)) begin
      n_err++;
      $display("FAIL rst_mid fresh: got %0d events ferr %0d first %h want 1 event %h", gotv.size(),
               nf, gotv.size() > 0 ? gotv[0].data : 8'hxx, expq[0].data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rx_a[i]  = 1'b1;
      ack_a[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_single(0, 8'hA5);
    test_glitch();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_random();
    test_reset_mid();
    test_single(2, 8'hA5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
